// File: rtl/jam_cost_arbiter.sv
// rtl/jam_cost_arbiter.sv - round-robin arbiter sharing one cost table among NREQ search engines
// Optional burst lock enabled by defining JAM_ARB_LOCK_EN.
module jam_cost_arbiter #(
    parameter int NREQ      = 4,
    parameter int WW        = 3,
    parameter int CW        = 7,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 8
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [NREQ-1:0]      REQ,
    input  logic [NREQ*WW-1:0]   REQ_W,
    input  logic [NREQ*WW-1:0]   REQ_J,
    input  logic [NREQ-1:0]      REQ_LOCK,
    output logic [NREQ-1:0]      GNT,
    output logic [WW-1:0]        W,
    output logic [WW-1:0]        J,
    input  logic [CW-1:0]        Cost,
    input  logic                 TBL_RDY,
    output logic [NREQ-1:0]      RSP_VALID,
    output logic [CW-1:0]        RSP_COST,
    input  logic                 FLUSH,
    output logic                 FLUSH_DONE,
    output logic                 BUSY
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
`ifdef JAM_ARB_LOCK_EN
        LOCK  = 2'd3,
`endif
        DRAIN = 2'd2
    } state_t;

    state_t                 state, state_nxt;
    logic [PW-1:0]          ptr;
    logic [RD_LAT:0]        pipe_vld;
    logic [RD_LAT:0][PW-1:0] pipe_idx;
    logic                   pipe_empty;
    logic [PW-1:0]          win, sel;
    logic                   win_found, sel_found, grant_ok;
    logic [PW:0]            cand;

    assign pipe_empty = ~|pipe_vld;

    // Scan downward so the lowest offset from the pointer is the final winner.
    always_comb begin
        win       = '0;
        win_found = 1'b0;
        cand      = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + (PW+1)'(k);
            if (cand >= (PW+1)'(NREQ))
                cand = cand - (PW+1)'(NREQ);
            if (REQ[cand[PW-1:0]]) begin
                win       = cand[PW-1:0];
                win_found = 1'b1;
            end
        end
    end

`ifdef JAM_ARB_LOCK_EN
    localparam int BW = $clog2(MAX_BURST + 1);
    logic [PW-1:0] own;
    logic [BW-1:0] burst;
    logic          hold;

    // Lock persists only while the owner keeps both lines up and has burst budget left.
    assign hold = (state == LOCK) && REQ[own] && REQ_LOCK[own] && (burst < BW'(MAX_BURST));

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            own   <= '0;
            burst <= '0;
        end else if (grant_ok) begin
            if (hold) begin
                burst <= burst + 1'b1;
            end else begin
                own   <= sel;
                burst <= BW'(1);
            end
        end
    end
`else
    logic unused_lock;
    assign unused_lock = (^REQ_LOCK) ^ (MAX_BURST > 0);
`endif

    always_comb begin
        sel       = win;
        sel_found = win_found;
`ifdef JAM_ARB_LOCK_EN
        if (hold) begin
            sel       = own;
            sel_found = 1'b1;
        end
`endif
    end

    assign grant_ok = RST_N && TBL_RDY && !FLUSH && (state != DRAIN) && sel_found;
    assign GNT      = grant_ok ? (NREQ'(1) << sel) : '0;
    assign BUSY     = (state != IDLE) || !pipe_empty;

    always_comb begin
        state_nxt  = state;
        FLUSH_DONE = 1'b0;
        case (state)
            IDLE:  if (!FLUSH && |REQ) state_nxt = RUN;
            RUN: begin
                if (FLUSH)                   state_nxt = DRAIN;
                else if (!(|REQ) && pipe_empty) state_nxt = IDLE;
            end
`ifdef JAM_ARB_LOCK_EN
            LOCK: begin
                if (FLUSH)      state_nxt = DRAIN;
                else if (!hold) state_nxt = RUN;
            end
`endif
            DRAIN: begin
                if (pipe_empty) begin
                    state_nxt  = IDLE;
                    FLUSH_DONE = RST_N;
                end
            end
            default: state_nxt = IDLE;
        endcase
`ifdef JAM_ARB_LOCK_EN
        if (grant_ok && REQ_LOCK[sel] && !hold)
            state_nxt = LOCK;
`endif
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state     <= IDLE;
            ptr       <= '0;
            W         <= '0;
            J         <= '0;
            pipe_vld  <= '0;
            pipe_idx  <= '0;
            RSP_VALID <= '0;
            RSP_COST  <= '0;
        end else begin
            state    <= state_nxt;
            pipe_vld <= {pipe_vld[RD_LAT-1:0], grant_ok};
            pipe_idx <= {pipe_idx[RD_LAT-1:0], sel};
            if (grant_ok) begin
                ptr <= (sel == PW'(NREQ - 1)) ? '0 : sel + 1'b1;
                W   <= REQ_W[int'(sel)*WW +: WW];
                J   <= REQ_J[int'(sel)*WW +: WW];
            end
            // Tag at the last stage lines up with the cycle Cost is valid.
            RSP_VALID <= pipe_vld[RD_LAT] ? (NREQ'(1) << pipe_idx[RD_LAT]) : '0;
            if (pipe_vld[RD_LAT])
                RSP_COST <= Cost;
        end
    end
endmodule
